uart_tx_frame: RTL and testbench

- Parametrised successor to the single-format UART transmitter that sits downstream of the character FIFO.
- Pops words from a first-word-fall-through FIFO through an active-low read strobe.
- Serialises each word with configurable data width, bit order, stop-bit count and baud divider.
- Supports back-to-back frames with no idle gap, and reports busy and frame-done status to the top level.

---
 rtl/uart_tx_frame.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter that pops words from a FWFT FIFO through an active-low read strobe.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int CDIV       = 2,
   parameter int STOP_BITS  = 1,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 n_empty,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 n_rd,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int DW = (CDIV > 1) ? $clog2(CDIV) : 1;
   localparam int CW = 4;
   localparam logic [DW-1:0] DIV_MAX   = DW'(CDIV - 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP  = 3'd4
   } state_t;

   state_t               state, state_d;
   logic [DW-1:0]        div, div_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [DATA_BITS-1:0] shreg, shreg_d, shreg_sh;
   logic                 tx_d, n_rd_d, busy_d, frame_done_d;
   logic                 wrap, load, nxt_bit;
`ifdef UART_TX_PARITY_EN
   logic                 par, par_d;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         div        <= '0;
         cnt        <= '0;
         shreg      <= '0;
         tx         <= 1'b1;
         n_rd       <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         div        <= div_d;
         cnt        <= cnt_d;
         shreg      <= shreg_d;
         tx         <= tx_d;
         n_rd       <= n_rd_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
`ifdef UART_TX_PARITY_EN
         par        <= par_d;
`endif
      end
   end

   // Next bit comes off the end of the shift register selected by MSB_FIRST.
   always_comb begin
      nxt_bit  = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
      shreg_sh = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
   end

   always_comb begin
      state_d = state;
      div_d   = div;
      cnt_d   = cnt;
      shreg_d = shreg;
      tx_d    = tx;
      n_rd_d  = 1'b1;
      busy_d  = busy;
      load    = 1'b0;
      wrap    = (div == DIV_MAX);
`ifdef UART_TX_PARITY_EN
      par_d   = par;
`endif
      if (state != IDLE) begin
         div_d = wrap ? '0 : div + 1'b1;
      end

      case (state)
         IDLE: begin
            tx_d = 1'b1;
            if (n_empty) load = 1'b1;
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               cnt_d   = '0;
               tx_d    = nxt_bit;
               shreg_d = shreg_sh;
            end
         end
         DATA: begin
            if (wrap) begin
               if (cnt == LAST_DATA) begin
                  cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  cnt_d   = cnt + 1'b1;
                  tx_d    = nxt_bit;
                  shreg_d = shreg_sh;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               if (cnt == LAST_STOP) begin
                  // Gapless hand-off when the FIFO already holds the next word.
                  if (n_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         state_d = START;
         shreg_d = data_in;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         div_d   = '0;
         cnt_d   = '0;
         n_rd_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^data_in) ^ (PARITY_ODD != 0);
`endif
      end

      frame_done_d = (state_d == STOP) && (div_d == DIV_MAX) && (cnt_d == LAST_STOP);
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three configurations (default, 7-bit LSB-first 2-stop CDIV=3,
// CDIV=1 odd parity) share one FIFO model; expected frames are hand-written bit strings.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [8:0] head = '0;
   logic       nonempty = 1'b0;
   int         sel = 0;

   logic       n_empty_a, n_empty_b, n_empty_c;
   logic       n_rd_a, n_rd_b, n_rd_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;
   logic       fd_a, fd_b, fd_c;
   logic       tx_s, n_rd_s, busy_s, fd_s;

   logic [8:0] fifo[$];
   logic       exp_q[$];
   int         errs = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   assign n_empty_a = (sel == 0) && nonempty;
   assign n_empty_b = (sel == 1) && nonempty;
   assign n_empty_c = (sel == 2) && nonempty;

   assign tx_s   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
   assign n_rd_s = (sel == 0) ? n_rd_a : (sel == 1) ? n_rd_b : n_rd_c;
   assign busy_s = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
   assign fd_s   = (sel == 0) ? fd_a   : (sel == 1) ? fd_b   : fd_c;

   uart_tx_frame u_a (
      .clk(clk), .n_rst(n_rst), .n_empty(n_empty_a), .data_in(head[7:0]),
      .n_rd(n_rd_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
   );

   uart_tx_frame #(.DATA_BITS(7), .CDIV(3), .STOP_BITS(2), .MSB_FIRST(0)) u_b (
      .clk(clk), .n_rst(n_rst), .n_empty(n_empty_b), .data_in(head[6:0]),
      .n_rd(n_rd_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
   );

   uart_tx_frame #(.CDIV(1), .PARITY_ODD(1)) u_c (
      .clk(clk), .n_rst(n_rst), .n_empty(n_empty_c), .data_in(head[7:0]),
      .n_rd(n_rd_c), .tx(tx_c), .busy(busy_c), .frame_done(fd_c)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   task automatic fifo_upd();
      nonempty = (fifo.size() > 0);
      head     = nonempty ? fifo[0] : 9'd0;
   endtask

   // Append a frame given as a bit string sent left to right, each bit held cdiv cycles.
   task automatic add_frame(input logic [15:0] bits, input int n, input int cdiv);
      for (int i = n - 1; i >= 0; i--)
         for (int k = 0; k < cdiv; k++) exp_q.push_back(bits[i]);
   endtask

   // Called at a negedge right after words are pushed; cycle 1 is the cycle after the load edge.
   task automatic watch(input int len, input int rd_exp, input int fd_exp, input int flen, input bit post);
      int rd_n = 0;
      int fd_n = 0;
      int busy_lo = 0;
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         chk("tx", tx_s, (i <= exp_q.size()) ? int'(exp_q[i-1]) : 1);
         if (!n_rd_s) begin
            chk("n_rd_cycle", i, rd_n * flen + 1);
            rd_n++;
            if (fifo.size() > 0) void'(fifo.pop_front());
            fifo_upd();
         end
         if (fd_s) begin
            chk("frame_done_cycle", i, (fd_n + 1) * flen);
            fd_n++;
         end
         if (!busy_s) busy_lo++;
      end
      chk("n_rd_pulses", rd_n, rd_exp);
      chk("frame_done_pulses", fd_n, fd_exp);
      chk("busy_low_cycles", busy_lo, 0);
      if (post) begin
         @(negedge clk);
         chk("busy_after", busy_s, 0);
         chk("tx_after", tx_s, 1);
         chk("n_rd_after", n_rd_s, 1);
         chk("frame_done_after", fd_s, 0);
      end
      exp_q.delete();
   endtask

   task automatic push(input logic [8:0] w);
      fifo.push_back(w);
      fifo_upd();
   endtask

`ifdef UART_TX_PARITY_EN
   localparam logic [15:0] FA_A = 16'b0_01100001_1_1;
   localparam logic [15:0] FB_A = 16'b0_01100010_1_1;
   localparam logic [15:0] FA_C = 16'b0_01100001_0_1;
   localparam logic [15:0] FB_C = 16'b0_01100010_0_1;
   localparam logic [15:0] F_B  = 16'b0_1000001_0_11;
   localparam int NA = 11, NB = 11, NC = 11;
`else
   localparam logic [15:0] FA_A = 16'b0_01100001_1;
   localparam logic [15:0] FB_A = 16'b0_01100010_1;
   localparam logic [15:0] FA_C = 16'b0_01100001_1;
   localparam logic [15:0] FB_C = 16'b0_01100010_1;
   localparam logic [15:0] F_B  = 16'b0_1000001_11;
   localparam int NA = 10, NB = 10, NC = 10;
`endif

   initial begin
      #2 n_rst = 1'b0;
      #1 n_rst = 1'b1;

      // Reset state held while the FIFO is empty.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("reset_tx", tx_s, 1);
            chk("reset_n_rd", n_rd_s, 1);
            chk("reset_busy", busy_s, 0);
            chk("reset_frame_done", fd_s, 0);
         end
      end

      // Single frame, defaults.
      sel = 0;
      push(9'h61);
      add_frame(FA_A, NA, 2);
      watch(NA * 2, 1, 1, NA * 2, 1);

      // Back-to-back "a","b".
      repeat (2) @(negedge clk);
      push(9'h61);
      push(9'h62);
      add_frame(FA_A, NA, 2);
      add_frame(FB_A, NA, 2);
      watch(NA * 4, 2, 2, NA * 2, 1);

      // 7-bit LSB-first, two stop bits, CDIV=3.
      sel = 1;
      repeat (2) @(negedge clk);
      push(9'h41);
      add_frame(F_B, NB, 3);
      watch(NB * 3, 1, 1, NB * 3, 1);

      // CDIV=1 back-to-back, odd parity sense.
      sel = 2;
      repeat (2) @(negedge clk);
      push(9'h61);
      push(9'h62);
      add_frame(FA_C, NC, 1);
      add_frame(FB_C, NC, 1);
      watch(NC * 2, 2, 2, NC, 1);

      // Reset during data bit 3, then a fresh frame.
      sel = 0;
      repeat (2) @(negedge clk);
      push(9'h61);
      add_frame(FA_A, NA, 2);
      watch(9, 1, 0, NA * 2, 0);
      n_rst = 1'b0;
      #1;
      chk("abort_tx", tx_s, 1);
      chk("abort_busy", busy_s, 0);
      chk("abort_n_rd", n_rd_s, 1);
      chk("abort_frame_done", fd_s, 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      push(9'h62);
      add_frame(FB_A, NA, 2);
      watch(NA * 2, 1, 1, NA * 2, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
